cpu6_pipeline_ctrl: RTL and testbench
=====================================

Name: cpu6_pipeline_ctrl

Overview:
- Hazard and flush controller for the cpu6 5-stage pipeline (F, D, E, M, W).
- Drives the per-stage stall enables and the "flash" (bubble-insert) inputs of the IF/ID and ID/EX pipeline registers.
- Arbitrates among EX redirects (branch/jump), data-memory wait, load-use hazards, and the empty-pipeline drain protocol requested by serialising instructions (CSR).
- Contains the drain state machine that holds such an instruction in D until older instructions retire, then blocks younger instructions until it retires itself.

Parameters:
- DRAIN_CYCLES, 2: cycles the requester is held in D, counted only on non-stalled cycles. Equals the number of stages (E, M) that must empty ahead of it. Legal range 1..7.
- REGADDR_W, 5: register-index width.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- redirectE, in, 1: taken branch or jump resolved in E.
- mem_stall, in, 1: data memory not ready; freezes F, D, E.
- memtoregE, in, 1: load in E.
- rdE, in, REGADDR_W: destination register of the instruction in E.
- rs1D, in, REGADDR_W: source 1 of the instruction in D.
- rs2D, in, REGADDR_W: source 2 of the instruction in D.
- empty_pipeline_reqD, in, 1: instruction in D requires an empty pipeline.
- empty_pipeline_reqW, in, 1: requester is retiring in W this cycle.
- stallF, out, 1: hold PC.
- stallD, out, 1: hold IF/ID register.
- stallE, out, 1: hold ID/EX register.
- flashD, out, 1: load a bubble into IF/ID.
- flashE, out, 1: load a bubble into ID/EX.
- drain_busy, out, 1: FSM not IDLE.

Behaviour:
- State (registered): state ∈ {IDLE, DRAIN, HOLD}; cnt, 3 bits.
- Reset values: state=IDLE, cnt=0.
- Outputs while reset=1: flashD=1, flashE=1, stallF/D/E=0, drain_busy=0.
- Outputs are combinational from the current state and inputs. No added latency: the effect appears at the next clk edge.

Priority per cycle (highest first):
1. redirectE: flashD=1, flashE=1, all stalls 0. Overrides everything, including mem_stall (the E instruction has already resolved).
2. mem_stall: stallF=stallD=stallE=1, flashD=flashE=0. The FSM and cnt are frozen.
3. Load-use: condition is memtoregE & rdE!=0 & (rdE==rs1D | rdE==rs2D). Response: stallF=stallD=1, flashE=1, for exactly one cycle per occurrence.
4. Drain FSM outputs, defined below.
5. Otherwise: all outputs 0.

FSM transitions:
- IDLE:
  - empty_pipeline_reqD=1, no redirect, no mem_stall, no load-use → DRAIN, cnt=DRAIN_CYCLES-1.
  - Output in the entering cycle: stallF=stallD=1, flashE=1.
- DRAIN:
  - Outputs: stallF=stallD=1, flashE=1.
  - cnt>0: cnt decrements each non-stalled cycle.
  - cnt==0: this cycle's outputs are all 0, so the requester advances into E; next state HOLD.
  - Total time the requester spends in D = DRAIN_CYCLES+1 cycles, plus any mem_stall cycles.
- HOLD:
  - Outputs: stallF=stallD=1, flashD=0, flashE=1. Younger instructions stay in F/D and only bubbles follow the requester.
  - empty_pipeline_reqW=1 → IDLE. Outputs are already released in that same cycle (stalls 0, flashE 0).
- Redirect in DRAIN: the requester is younger than the redirecting instruction and is flushed; FSM → IDLE, cnt=0.
- Redirect in HOLD: flushes D/E normally; FSM stays in HOLD until empty_pipeline_reqW.
- Load-use in IDLE with empty_pipeline_reqD=1: the load-use bubble is served first; DRAIN is entered on the following cycle if the request persists.
- empty_pipeline_reqW in IDLE or DRAIN: ignored.
- Reset mid-DRAIN or mid-HOLD: next state IDLE, cnt=0. No residual stall after reset deasserts.
- drain_busy = (state != IDLE).

Test Plan:
1. Reset held 2 cycles, all inputs 0 → during reset flashD=flashE=1; after release all outputs 0, drain_busy=0.
2. Load-use: memtoregE=1, rdE=5, rs1D=5 for one cycle → stallF=stallD=flashE=1 that cycle. Repeat with rdE=0, rs1D=0 → no stall.
3. Drain, DRAIN_CYCLES=2: empty_pipeline_reqD=1 at cycle 0.
   - Cycles 0–1: stallD=1, flashE=1.
   - Cycle 2: outputs 0.
   - Cycles 3–5: HOLD with stallF=1, flashE=1.
   - empty_pipeline_reqW=1 at cycle 6 → outputs 0 at cycle 6, drain_busy=0 from cycle 7.
4. mem_stall=1 for 3 cycles during DRAIN at cnt=1 → stallE=1, flashE=0, cnt held at 1. After mem_stall drops, advance takes exactly one more DRAIN cycle.
5. redirectE=1 in DRAIN → flashD=flashE=1, stalls 0, next state IDLE. redirectE=1 coincident with mem_stall=1 → flashes asserted, stalls 0.
6. Reset asserted in HOLD → state IDLE next cycle. A subsequent empty_pipeline_reqW=1 produces no response.

Source files
------------

// File: rtl/cpu6_pipeline_ctrl_if.sv
// cpu6_pipeline_ctrl_if: hazard inputs and stall/flash outputs between the cpu6 datapath and its pipeline controller
interface cpu6_pipeline_ctrl_if #(
    parameter int REGADDR_W = 5
);
    logic                 redirectE;
    logic                 mem_stall;
    logic                 memtoregE;
    logic [REGADDR_W-1:0] rdE;
    logic [REGADDR_W-1:0] rs1D;
    logic [REGADDR_W-1:0] rs2D;
    logic                 empty_pipeline_reqD;
    logic                 empty_pipeline_reqW;
    logic                 stallF;
    logic                 stallD;
    logic                 stallE;
    logic                 flashD;
    logic                 flashE;
    logic                 drain_busy;

    modport master (
        input  redirectE, mem_stall, memtoregE, rdE, rs1D, rs2D,
               empty_pipeline_reqD, empty_pipeline_reqW,
        output stallF, stallD, stallE, flashD, flashE, drain_busy
    );

    modport slave (
        output redirectE, mem_stall, memtoregE, rdE, rs1D, rs2D,
               empty_pipeline_reqD, empty_pipeline_reqW,
        input  stallF, stallD, stallE, flashD, flashE, drain_busy
    );
endinterface

// File: rtl/cpu6_pipeline_ctrl.sv
// cpu6_pipeline_ctrl: stall/flush arbitration and empty-pipeline drain FSM for the cpu6 5-stage pipeline
module cpu6_pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int REGADDR_W    = 5
) (
    input logic                  clk,
    input logic                  reset,
    cpu6_pipeline_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, DRAIN, HOLD} state_t;
    localparam logic [2:0] CNT_INIT = 3'(DRAIN_CYCLES - 1);
    // {stallF, stallD, stallE, flashD, flashE}
    localparam logic [4:0] O_NONE   = 5'b00000;
    localparam logic [4:0] O_FLUSH  = 5'b00011;
    localparam logic [4:0] O_FREEZE = 5'b11100;
    localparam logic [4:0] O_BUBBLE = 5'b11001;
    state_t     state;
    logic [2:0] cnt;
    logic       load_use;
    logic       fsm_hold;
    logic [4:0] o;

    // Resolve the highest-priority hazard into this cycle's stall/flash pattern
    always_comb begin
        load_use = bus.memtoregE && bus.rdE != {REGADDR_W{1'b0}} &&
                   (bus.rdE == bus.rs1D || bus.rdE == bus.rs2D);
        fsm_hold = (state == IDLE  && bus.empty_pipeline_reqD) ||
                   (state == DRAIN && cnt != 3'd0) ||
                   (state == HOLD  && !bus.empty_pipeline_reqW);
        o = reset         ? O_FLUSH  :
            bus.redirectE ? O_FLUSH  :
            bus.mem_stall ? O_FREEZE :
            load_use      ? O_BUBBLE :
            fsm_hold      ? O_BUBBLE : O_NONE;
    end

    assign {bus.stallF, bus.stallD, bus.stallE, bus.flashD, bus.flashE} = o;
    assign bus.drain_busy = !reset && state != IDLE;

    // Drain FSM: hold the requester in D for DRAIN_CYCLES, then starve younger work until it retires
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else if (bus.redirectE) begin
            if (state == DRAIN) begin
                state <= IDLE;
                cnt   <= 3'd0;
            end else if (state == HOLD && bus.empty_pipeline_reqW) begin
                state <= IDLE;
            end
        end else if (!bus.mem_stall) begin
            case (state)
                IDLE: if (bus.empty_pipeline_reqD && !load_use) begin
                    state <= DRAIN;
                    cnt   <= CNT_INIT;
                end
                DRAIN: if (!load_use) begin
                    if (cnt != 3'd0) cnt <= cnt - 3'd1;
                    else state <= HOLD;
                end
                HOLD: if (bus.empty_pipeline_reqW) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu6_pipeline_ctrl.sv
// tb_cpu6_pipeline_ctrl: directed scoreboard bench for the cpu6 pipeline controller
module tb_cpu6_pipeline_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [5:0] e;
        string      n;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    cpu6_pipeline_ctrl_if #(.REGADDR_W(5)) bus ();

    cpu6_pipeline_ctrl #(.DRAIN_CYCLES(2), .REGADDR_W(5)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // expected vector bits: {stallF, stallD, stallE, flashD, flashE, drain_busy}
    task automatic step(input logic r, input logic rd, input logic ms, input logic mt,
                        input logic [4:0] re, input logic [4:0] r1, input logic [4:0] r2,
                        input logic qd, input logic qw, input logic [5:0] e, input string n);
        exp_t x;
        @(posedge clk);
        #1;
        reset                   = r;
        bus.redirectE           = rd;
        bus.mem_stall           = ms;
        bus.memtoregE           = mt;
        bus.rdE                 = re;
        bus.rs1D                = r1;
        bus.rs2D                = r2;
        bus.empty_pipeline_reqD = qd;
        bus.empty_pipeline_reqW = qw;
        x.e = e;
        x.n = n;
        q.push_back(x);
    endtask

    task automatic idle(input logic qd, input logic qw, input logic [5:0] e, input string n);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, qd, qw, e, n);
    endtask

    initial begin
        exp_t       x;
        logic [5:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x   = q.pop_front();
                act = {bus.stallF, bus.stallD, bus.stallE, bus.flashD, bus.flashE, bus.drain_busy};
                checks++;
                if (act !== x.e) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b", x.n, act, x.e);
                end
            end
        end
    end

    initial begin
        bus.redirectE = 0; bus.mem_stall = 0; bus.memtoregE = 0;
        bus.rdE = 0; bus.rs1D = 0; bus.rs2D = 0;
        bus.empty_pipeline_reqD = 0; bus.empty_pipeline_reqW = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000110, "reset0");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000110, "reset1");
        idle(0, 0, 6'b000000, "post_reset");
        step(0, 0, 0, 1, 5, 5, 0, 0, 0, 6'b110010, "lu_rs1");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 6'b000000, "lu_x0");
        step(0, 0, 0, 1, 7, 3, 7, 0, 0, 6'b110010, "lu_rs2");
        step(0, 0, 0, 0, 5, 5, 5, 0, 0, 6'b000000, "no_load");
        step(0, 0, 0, 1, 6, 5, 4, 0, 0, 6'b000000, "lu_nomatch");
        idle(1, 0, 6'b110010, "drain_enter");
        idle(1, 1, 6'b110011, "drain_c1_reqw_ignored");
        idle(1, 0, 6'b000001, "drain_release");
        idle(0, 0, 6'b110011, "hold3");
        idle(0, 0, 6'b110011, "hold4");
        idle(0, 0, 6'b110011, "hold5");
        idle(0, 1, 6'b000001, "hold_exit");
        idle(0, 0, 6'b000000, "idle_after_drain");
        idle(1, 0, 6'b110010, "ms_enter");
        step(0, 0, 1, 0, 0, 0, 0, 1, 0, 6'b111001, "ms_c1");
        step(0, 0, 1, 0, 0, 0, 0, 1, 0, 6'b111001, "ms_c2");
        step(0, 0, 1, 0, 0, 0, 0, 1, 0, 6'b111001, "ms_c3");
        idle(1, 0, 6'b110011, "ms_cnt_held");
        idle(1, 0, 6'b000001, "ms_release");
        idle(0, 0, 6'b110011, "ms_hold");
        idle(0, 1, 6'b000001, "ms_hold_exit");
        idle(0, 0, 6'b000000, "ms_idle");
        idle(1, 0, 6'b110010, "rd_enter");
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 6'b000111, "redirect_drain");
        idle(0, 0, 6'b000000, "redirect_to_idle");
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 6'b000110, "redirect_memstall");
        idle(1, 0, 6'b110010, "rh_enter");
        idle(1, 0, 6'b110011, "rh_drain");
        idle(1, 0, 6'b000001, "rh_release");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000111, "redirect_hold");
        idle(0, 0, 6'b110011, "hold_after_redirect");
        idle(0, 1, 6'b000001, "rh_exit");
        idle(0, 0, 6'b000000, "rh_idle");
        step(0, 0, 0, 1, 3, 3, 0, 1, 0, 6'b110010, "lu_before_drain");
        idle(1, 0, 6'b110010, "drain_after_lu");
        idle(1, 0, 6'b110011, "lud_drain");
        idle(1, 0, 6'b000001, "lud_release");
        idle(0, 0, 6'b110011, "lud_hold");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000110, "reset_in_hold");
        idle(0, 1, 6'b000000, "reqw_after_reset");
        idle(0, 1, 6'b000000, "reqw_idle");
        idle(0, 0, 6'b000000, "final_idle");
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
